// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions: default widths, accumulator FSM states and
// the helper that sizes operand counters. Used by the adder stage, the
// accumulator and the result sink.
package tpu_pkg;

    localparam int IN_W_DEF  = 5;
    localparam int ACC_W_DEF = 12;
    localparam int BURST_DEF = 4;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_e;

    // Bits needed to hold a count of 0..burst inclusive.
    function automatic int cnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/tpu_sum_accumulator_if.sv
// Stream bundle for the sum accumulator: sum input channel plus the group
// result channel. The block itself is the slave; the adder/sink side is master.
interface tpu_sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/tpu_acc_add.sv
// Accumulator adder: acc + zero-extended operand with carry-out.
// Optional macro TPU_ACC_SAT_EN clamps the sum to all-ones on carry instead of
// wrapping. Once clamped, any nonzero operand carries again, so the clamp
// holds for the rest of the group without extra state.
module tpu_acc_add #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  in_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);
    logic [ACC_W:0] sum_full;

    // One extra bit captures the carry out of the ACC_W-bit add.
    always_comb begin
        sum_full = {1'b0, acc_i} + {{(ACC_W + 1 - IN_W){1'b0}}, in_i};
        carry_o  = sum_full[ACC_W];
`ifdef TPU_ACC_SAT_EN
        sum_o    = carry_o ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
        sum_o    = sum_full[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/tpu_sum_accumulator.sv
// Sum accumulator: reduces groups of up to BURST incoming sums into one wide
// result. A group ends on in_last or on the BURST-th operand; the result is
// held in DONE until the sink takes it. All outputs decode from registers.
// Optional macro TPU_ACC_SAT_EN (in tpu_acc_add) selects saturating overflow.
module tpu_sum_accumulator
    import tpu_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tpu_sum_accumulator_if.slave bus
);
    localparam int CNT_W = cnt_w(BURST);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    tpu_acc_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i   (acc_q),
        .in_i    (bus.in_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign accept  = bus.in_valid && (state_q == ACC);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next state: accumulate in ACC, hand the result off in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    // in_last on the BURST-th operand is still one termination.
                    if (bus.in_last || (cnt_inc == CNT_W'(BURST))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State and group registers; reset discards any partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode from state; result fields read zero outside DONE.
    always_comb begin
        bus.in_ready  = (state_q == ACC);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = (state_q == DONE) ? acc_q : '0;
        bus.out_count = (state_q == DONE) ? cnt_q : '0;
        bus.out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
    end
endmodule

// File: tb/tb_tpu_sum_accumulator.sv
// Directed bench for tpu_sum_accumulator. Two instances share one input
// stream: a 12-bit accumulator and a 6-bit one that exercises overflow.
module tb_tpu_sum_accumulator;
    import tpu_pkg::*;

    localparam int CW = cnt_w(4);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] in_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    tpu_sum_accumulator_if #(.IN_W(5), .ACC_W(12), .CNT_W(CW)) ifa ();
    tpu_sum_accumulator_if #(.IN_W(5), .ACC_W(6),  .CNT_W(CW)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    tpu_sum_accumulator #(.IN_W(5), .ACC_W(12), .BURST(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    tpu_sum_accumulator #(.IN_W(5), .ACC_W(6), .BURST(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and return just after the edge that accepts it.
    task automatic send(input logic [4:0] d, input logic l);
        int w;
        w        = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!ifa.in_ready && w < 20) begin
            cyc();
            w++;
        end
        if (!ifa.in_ready) chk("send_timeout", 32'(ifa.in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, sa, sb;
        bit ob;
        logic [4:0] d;
        logic l;

        // Reset state
        #12;
        chk("rst_in_ready",  32'(ifa.in_ready),  32'd1);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_out_data",  32'(ifa.out_data),  32'd0);
        chk("rst_out_count", 32'(ifa.out_count), 32'd0);
        chk("rst_out_ovf",   32'(ifa.out_ovf),   32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: full burst of 30s, sink always ready
        out_ready = 1'b1;
        repeat (4) send(5'd30, 1'b0);
        chk("t1_valid", 32'(ifa.out_valid), 32'd1);
        chk("t1_ready", 32'(ifa.in_ready),  32'd0);
        chk("t1_data",  32'(ifa.out_data),  32'd120);
        chk("t1_count", 32'(ifa.out_count), 32'd4);
        chk("t1_ovf",   32'(ifa.out_ovf),   32'd0);
        cyc();
        chk("t1_valid_one_cycle", 32'(ifa.out_valid), 32'd0);
        chk("t1_ready_back",      32'(ifa.in_ready),  32'd1);

        // 2: early termination, then fresh group starts from zero
        send(5'd7, 1'b0);
        send(5'd9, 1'b1);
        chk("t2_valid", 32'(ifa.out_valid), 32'd1);
        chk("t2_data",  32'(ifa.out_data),  32'd16);
        chk("t2_count", 32'(ifa.out_count), 32'd2);
        cyc();
        send(5'd5, 1'b1);
        chk("t2_next_data",  32'(ifa.out_data),  32'd5);
        chk("t2_next_count", 32'(ifa.out_count), 32'd1);
        cyc();

        // 3: 6-bit accumulator overflow (30+30+30 carries)
        repeat (4) send(5'd30, 1'b0);
        chk("t3_a_data", 32'(ifa.out_data), 32'd120);
`ifdef TPU_ACC_SAT_EN
        chk("t3_b_data", 32'(ifb.out_data), 32'd63);
`else
        chk("t3_b_data", 32'(ifb.out_data), 32'd56);
`endif
        chk("t3_b_ovf",   32'(ifb.out_ovf),   32'd1);
        chk("t3_b_count", 32'(ifb.out_count), 32'd4);
        cyc();

        // 4: backpressure in DONE with input pending
        out_ready = 1'b0;
        send(5'd1, 1'b0);
        send(5'd2, 1'b0);
        send(5'd3, 1'b0);
        send(5'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 5'd31;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold_valid", 32'(ifa.out_valid), 32'd1);
            chk("t4_hold_data",  32'(ifa.out_data),  32'd10);
            chk("t4_hold_count", 32'(ifa.out_count), 32'd4);
            chk("t4_hold_ready", 32'(ifa.in_ready),  32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("t4_release_ready", 32'(ifa.in_ready), 32'd1);
        in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t4_after_valid", 32'(ifa.out_valid), 32'd1);
        chk("t4_after_data",  32'(ifa.out_data),  32'd31);
        chk("t4_after_count", 32'(ifa.out_count), 32'd1);
        cyc();

        // 5: reset mid-group discards partial sum
        send(5'd3, 1'b0);
        send(5'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(ifa.in_ready),  32'd1);
        chk("t5_rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("t5_rst_data",  32'(ifa.out_data),  32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        repeat (4) send(5'd1, 1'b0);
        chk("t5_data",  32'(ifa.out_data),  32'd4);
        chk("t5_count", 32'(ifa.out_count), 32'd4);
        cyc();

        // 6: random groups with bubbles and backpressure vs reference sums
        for (int g = 0; g < 1000; g++) begin
            out_ready = 1'b0;
            n  = $urandom_range(1, 4);
            sa = 0;
            sb = 0;
            ob = 1'b0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) cyc();
                d  = 5'($urandom_range(0, 31));
                l  = (i == n - 1) ? ((n < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                sa = sa + int'(d);
                sb = sb + int'(d);
                if (sb > 63) begin
                    ob = 1'b1;
`ifdef TPU_ACC_SAT_EN
                    sb = 63;
`else
                    sb = sb - 64;
`endif
                end
                send(d, l);
            end
            chk("t6_valid",   32'(ifa.out_valid), 32'd1);
            chk("t6_a_data",  32'(ifa.out_data),  32'(sa));
            chk("t6_a_count", 32'(ifa.out_count), 32'(n));
            chk("t6_a_ovf",   32'(ifa.out_ovf),   32'd0);
            chk("t6_b_data",  32'(ifb.out_data),  32'(sb));
            chk("t6_b_ovf",   32'(ifb.out_ovf),   32'(ob));
            k = $urandom_range(0, 2);
            repeat (k) cyc();
            out_ready = 1'b1;
            cyc();
            chk("t6_drained", 32'(ifa.out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
